// File: rtl/lsu_pkg.sv
// lsu_pkg: bus layouts, load-type codes and FSM encoding shared by the load/store stage.
// Rev 1.0
`default_nettype none

package lsu_pkg;

  localparam int EXU_LSU_W = 159;
  localparam int LSU_WBU_W = 151;

  localparam logic [3:0] MEM_RE_NONE = 4'b0000;
  localparam logic [3:0] MEM_RE_LB   = 4'b0001;
  localparam logic [3:0] MEM_RE_LH   = 4'b0011;
  localparam logic [3:0] MEM_RE_LW   = 4'b1111;
  localparam logic [3:0] MEM_RE_LBU  = 4'b0101;
  localparam logic [3:0] MEM_RE_LHU  = 4'b0111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Field order is MSB first and fixes the bit offsets of both buses.
  typedef struct packed {
    logic        csr_we;
    logic [1:0]  addr_lo;
    logic [3:0]  mem_re;
    logic [11:0] csr_addr;
    logic [31:0] pc;
    logic [31:0] alu_res;
    logic [31:0] csr_val;
    logic        res_from_mem;
    logic        res_from_csr;
    logic        gr_we;
    logic [4:0]  rd;
    logic        excp;
    logic        xret;
    logic        brk;
    logic        jmp_flag;
    logic [31:0] jmp_target;
  } exu_lsu_bus_t;

  typedef struct packed {
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] pc;
    logic [31:0] csr_val;
    logic        gr_we;
    logic [4:0]  rd;
    logic [31:0] rd_wdata;
    logic        excp;
    logic        xret;
    logic        brk;
    logic        jmp_flag;
    logic [31:0] jmp_target;
  } lsu_wbu_bus_t;

  function automatic logic [31:0] word_addr(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_load_align.sv
// lsu_load_align: shifts the fetched word to the addressed byte lane and sign/zero-extends it.
// Rev 1.0
`default_nettype none

module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [3:0]  mem_re,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  assign shifted = rdata >> {addr_lo, 3'b000};

  // Unlisted nonzero codes fall through to the full word, same as LW.
  always_comb begin
    load_data = shifted;
    case (mem_re)
      MEM_RE_LB:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      MEM_RE_LBU: load_data = {24'h000000, shifted[7:0]};
      MEM_RE_LH:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      MEM_RE_LHU: load_data = {16'h0000, shifted[15:0]};
      default:    load_data = shifted;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu.sv
// lsu: load/store pipeline stage; holds one instruction, performs its data-memory read, hands off to write-back.
// Rev 1.0
`default_nettype none

module lsu
  import lsu_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 exu_valid_i,
  output logic                 exu_ready_o,
  input  logic [EXU_LSU_W-1:0] exu_lsu_bus_i,
  output logic                 dmem_req_o,
  output logic [31:0]          dmem_addr_o,
  input  logic                 dmem_gnt_i,
  input  logic                 dmem_rvalid_i,
  input  logic [31:0]          dmem_rdata_i,
  output logic                 valid_o,
  input  logic                 wbu_ready_i,
  output logic [LSU_WBU_W-1:0] lsu_wbu_bus_o
);

  logic [1:0]   state;
  logic [1:0]   state_nxt;
  exu_lsu_bus_t in_bus;
  exu_lsu_bus_t held;
  logic [31:0]  rdata_q;
  logic [31:0]  load_data;
  logic [31:0]  rd_wdata;
  logic         accept;
  lsu_wbu_bus_t wb_bus;

  assign in_bus      = exu_lsu_bus_t'(exu_lsu_bus_i);
  assign exu_ready_o = (state == ST_IDLE) | ((state == ST_DONE) & wbu_ready_i);
  assign accept      = exu_valid_i & exu_ready_o;

  assign dmem_req_o  = (state == ST_REQ);
  assign dmem_addr_o = word_addr(held.alu_res);
  assign valid_o     = (state == ST_DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = (in_bus.mem_re != MEM_RE_NONE) ? ST_REQ : ST_DONE;
        end
      end
      ST_REQ: begin
        if (dmem_gnt_i) begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (dmem_rvalid_i) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        // A new instruction can replace the one being handed off in the same cycle.
        if (wbu_ready_i) begin
          if (accept) begin
            state_nxt = (in_bus.mem_re != MEM_RE_NONE) ? ST_REQ : ST_DONE;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      held    <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        held <= in_bus;
      end
      // Responses outside WAIT are stale (e.g. from before a reset) and dropped.
      if ((state == ST_WAIT) && dmem_rvalid_i) begin
        rdata_q <= dmem_rdata_i;
      end
    end
  end

  lsu_load_align u_load_align (
    .rdata     (rdata_q),
    .addr_lo   (held.addr_lo),
    .mem_re    (held.mem_re),
    .load_data (load_data)
  );

  always_comb begin
    if (held.res_from_mem) begin
      rd_wdata = load_data;
    end else if (held.res_from_csr) begin
      rd_wdata = held.csr_val;
    end else begin
      rd_wdata = held.alu_res;
    end
  end

  always_comb begin
    wb_bus            = '0;
    wb_bus.csr_we     = held.csr_we;
    wb_bus.csr_addr   = held.csr_addr;
    wb_bus.pc         = held.pc;
    wb_bus.csr_val    = held.csr_val;
    wb_bus.gr_we      = held.gr_we;
    wb_bus.rd         = held.rd;
    wb_bus.rd_wdata   = rd_wdata;
    wb_bus.excp       = held.excp;
    wb_bus.xret       = held.xret;
    wb_bus.brk        = held.brk;
    wb_bus.jmp_flag   = held.jmp_flag;
    wb_bus.jmp_target = held.jmp_target;
  end

  assign lsu_wbu_bus_o = wb_bus;

endmodule

`default_nettype wire
